// File: rtl/erm16_core.sv
// erm16_core: 16-bit multicycle CPU, 4 clocks/instruction; define ERM16_MUL_EN to enable op 16 MUL
module erm16_core #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] di,
  output logic [15:0] addr_bus,
  output logic [15:0] do_data,
  output logic        wrmem,
  output logic        ioe,
  output logic        intreq
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;
  state_t state;
  logic [15:0] pc, ir, a, b, res, npc, opnd, imm, port, pc1;
  logic [15:0] r [8];
  logic z, n, c, v, fc, fv, wr, fl, take, mem_op;
  logic [16:0] add_r, sub_r;
  logic [7:0] cond;
  logic [6:0] op;
  logic [2:0] rd;
  assign op = ir[15:9];
  assign rd = ir[8:6];
  assign imm = {{10{ir[5]}}, ir[5:0]};
  assign port = {10'd0, ir[5:0]};
  assign opnd = op == 7'h09 ? imm : b;
  assign add_r = {1'b0, a} + {1'b0, opnd};
  assign sub_r = {1'b0, a} - {1'b0, b};
  assign pc1 = pc + 16'd1;
  assign cond = {~n, v, n, ~c, c, ~z, z, 1'b1};
  assign take = cond[rd];
  assign mem_op = op == 7'h0A || op == 7'h0B || op == 7'h0E || op == 7'h0F;
  assign npc = (op == 7'h0C || op == 7'h13) ? a :
               op == 7'h14 ? r[7] :
               (op == 7'h0D && take) ? pc1 + imm : pc1;
  // Results are consumed at the WB edge; A/B/IR are stable from EXEC onward
  always_comb begin
    res = a;
    fc = c;
    fv = v;
    wr = 1'b0;
    fl = 1'b0;
    case (op)
      7'h01, 7'h09: begin res = add_r[15:0]; fc = add_r[16]; fv = (a[15] == opnd[15]) && (add_r[15] != a[15]); wr = 1'b1; fl = 1'b1; end
      7'h02, 7'h12: begin res = sub_r[15:0]; fc = sub_r[16]; fv = (a[15] != b[15]) && (sub_r[15] != a[15]); wr = op == 7'h02; fl = 1'b1; end
      7'h03: begin res = a & b; fc = 1'b0; fv = 1'b0; wr = 1'b1; fl = 1'b1; end
      7'h04: begin res = a | b; fc = 1'b0; fv = 1'b0; wr = 1'b1; fl = 1'b1; end
      7'h07: begin res = a ^ b; fc = 1'b0; fv = 1'b0; wr = 1'b1; fl = 1'b1; end
      7'h10: begin res = {a[14:0], 1'b0}; fc = a[15]; fv = 1'b0; wr = 1'b1; fl = 1'b1; end
      7'h11: begin res = {1'b0, a[15:1]}; fc = a[0]; fv = 1'b0; wr = 1'b1; fl = 1'b1; end
      7'h05: begin res = imm; wr = 1'b1; end
      7'h08: begin res = b; wr = 1'b1; end
      7'h0A, 7'h0E: begin res = di; wr = 1'b1; end
`ifdef ERM16_MUL_EN
      7'h16: begin res = a * b; fc = 1'b0; fv = 1'b0; wr = 1'b1; fl = 1'b1; end
`else
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      ir <= '0;
      a <= '0;
      b <= '0;
      addr_bus <= '0;
      do_data <= '0;
      wrmem <= 1'b0;
      ioe <= 1'b0;
      intreq <= 1'b0;
      {z, n, c, v} <= '0;
      for (int i = 0; i < 8; i++) r[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          addr_bus <= pc;
          ioe <= 1'b0;
          state <= DECODE;
        end
        DECODE: begin
          ir <= di;
          a <= r[di[8:6]];
          b <= r[di[5:3]];
          state <= EXEC;
        end
        EXEC: begin
          if (mem_op) begin
            addr_bus <= op[2] ? port : b;
            ioe <= op[2];
            do_data <= a;
          end
          wrmem <= mem_op && op[0];
          intreq <= op == 7'h15;
          state <= WB;
        end
        WB: begin
          wrmem <= 1'b0;
          intreq <= 1'b0;
          if (wr) r[rd] <= res;
          if (op == 7'h13) r[7] <= pc1;
          if (fl) {z, n, c, v} <= {res == 16'd0, res[15], fc, fv};
          pc <= npc;
          state <= op == 7'h06 ? HALT : FETCH;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_erm16_core.sv
// tb_erm16_core: directed program run on erm16_core, observed through bus writes and halt behaviour
module tb_erm16_core;
  logic clk = 1'b0;
  logic rst;
  logic [15:0] di, addr_bus, do_data;
  logic wrmem, ioe, intreq;
  logic [15:0] mem [256];
  logic [15:0] wa [16];
  logic [15:0] wd [16];
  logic wi [16];
  logic [15:0] ea [9];
  logic [15:0] ed [9];
  logic ei [9];
  int wr_cnt = 0, run = 0, max_run = 0, irun = 0, imax = 0, int_cnt = 0;
  int checks = 0, errors = 0;
  logic [15:0] halt_addr;

  erm16_core dut (
    .clk(clk), .rst(rst), .di(di), .addr_bus(addr_bus), .do_data(do_data),
    .wrmem(wrmem), .ioe(ioe), .intreq(intreq)
  );

  always #5 clk = ~clk;
  // IO reads return A500 ^ port so IN results are recognisable
  assign di = ioe ? (16'hA500 ^ addr_bus) : mem[addr_bus[7:0]];

  always @(negedge clk) begin
    if (wrmem) begin
      if (wr_cnt < 16) begin
        wa[wr_cnt] = addr_bus;
        wd[wr_cnt] = do_data;
        wi[wr_cnt] = ioe;
      end
      wr_cnt++;
      run++;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (intreq) begin
      irun++;
      if (irun == 1) int_cnt++;
      if (irun > imax) imax = irun;
    end else irun = 0;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1E4F;
    mem[0]  = 16'h0A41; mem[1]  = 16'h1E44; mem[2]  = 16'h0A7F; mem[3]  = 16'h1241;
    mem[4]  = 16'h1E45; mem[5]  = 16'h1A43; mem[9]  = 16'h1AC1; mem[11] = 16'h1A81;
    mem[12] = 16'h0A90; mem[13] = 16'h2080; mem[14] = 16'h2080; mem[15] = 16'h2680;
    mem[16] = 16'h0A60; mem[17] = 16'h2240; mem[18] = 16'h1E48; mem[19] = 16'h1B01;
    mem[21] = 16'h1BC1; mem[23] = 16'h0278; mem[24] = 16'h1B81; mem[26] = 16'h0AC1;
    mem[27] = 16'h0458; mem[28] = 16'h1E49; mem[29] = 16'h1B81; mem[31] = 16'h1AC1;
    mem[32] = 16'h1E4A; mem[33] = 16'h1650; mem[34] = 16'h1538; mem[35] = 16'h1D43;
    mem[36] = 16'h0F28; mem[37] = 16'h1F0B; mem[38] = 16'h2A00; mem[39] = 16'h2D28;
    mem[40] = 16'h1F0C; mem[41] = 16'h0C00;
    mem[64] = 16'h1FC7; mem[65] = 16'h2800;
    ea = '{16'h0004, 16'h0005, 16'h0007, 16'h0008, 16'h0009, 16'h000A, 16'h0040, 16'h000B, 16'h000C};
    ei = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
`ifdef ERM16_MUL_EN
    ed = '{16'h0001, 16'h0000, 16'h0010, 16'h7FF0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hAF63, 16'hDD29};
`else
    ed = '{16'h0001, 16'h0000, 16'h0010, 16'h7FF0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'hAF63, 16'hAF63};
`endif
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr", addr_bus, 16'h0000);
    chk("rst_do", do_data, 16'h0000);
    chk("rst_wrmem", {15'd0, wrmem}, 16'h0000);
    chk("rst_ioe", {15'd0, ioe}, 16'h0000);
    chk("rst_intreq", {15'd0, intreq}, 16'h0000);
    rst = 1'b0;
    @(negedge clk);
    chk("fetch0_addr", addr_bus, 16'h0000);
    chk("fetch0_ioe", {15'd0, ioe}, 16'h0000);
    repeat (400) @(negedge clk);
    chk("wr_count", 16'(wr_cnt), 16'd9);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("wr%0d_addr", i), wa[i], ea[i]);
      chk($sformatf("wr%0d_data", i), wd[i], ed[i]);
      chk($sformatf("wr%0d_ioe", i), {15'd0, wi[i]}, {15'd0, ei[i]});
    end
    chk("wrmem_width", 16'(max_run), 16'd1);
    chk("int_count", 16'(int_cnt), 16'd1);
    chk("int_width", 16'(imax), 16'd1);
    halt_addr = addr_bus;
    chk("halt_addr", halt_addr, 16'h0029);
    repeat (40) @(negedge clk);
    chk("halt_frozen", addr_bus, 16'h0029);
    chk("halt_ioe", {15'd0, ioe}, 16'h0000);
    chk("halt_no_wr", 16'(wr_cnt), 16'd9);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_no_wr", 16'(wr_cnt), 16'd9);
    chk("abort_wrmem", {15'd0, wrmem}, 16'h0000);
    chk("abort_addr", addr_bus, 16'h0000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
